// File: rtl/grom_pkg.sv
// Shared types and default widths for the grom memory-side arbiters.
package grom_pkg;

  localparam int GROM_ADDR_W = 12;
  localparam int GROM_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, CPU, AUX} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_t;

endpackage

// File: rtl/grom_starve_cnt.sv
// Saturating starvation counter: clear wins over increment, sat flags the limit.
module grom_starve_cnt #(
  parameter int MAX   = 15,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign sat_o = (cnt_q == CNT_W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grom_mem_arbiter.sv
// Shares one synchronous RAM between the grom CPU and an auxiliary master:
// fixed CPU priority with a starvation-forced aux slot, reads steered back to the issuer.
module grom_mem_arbiter
  import grom_pkg::*;
#(
  parameter int ADDR_W   = GROM_ADDR_W,
  parameter int DATA_W   = GROM_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_ioreq,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              cpu_ram;
  logic              force_aux;
  owner_t            owner;
  owner_t            rd_owner_q, rd_owner_d;
  arb_state_t        state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, aux_rdata_q;

  // I/O accesses never compete for the RAM slot.
  assign cpu_ram = cpu_req & ~cpu_ioreq;

  grom_starve_cnt #(
    .MAX   (MAX_WAIT),
    .CNT_W (8)
  ) u_starve (
    .clk   (clk),
    .rst_n (reset_n),
    .inc_i (aux_req & ~aux_gnt),
    .clr_i (aux_gnt | ~aux_req),
    .sat_o (force_aux)
  );

  always_comb begin
    owner = OWN_NONE;
    if (force_aux && aux_req) begin
      owner = OWN_AUX;
    end else if (cpu_ram) begin
      owner = OWN_CPU;
    end else if (aux_req) begin
      owner = OWN_AUX;
    end
  end

  assign aux_gnt  = (owner == OWN_AUX);
  assign cpu_wait = cpu_ram & (owner != OWN_CPU);

  // Idle cycles keep the RAM address/data lines parked on their last value.
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = 1'b0;
    unique case (owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      OWN_AUX: begin
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_we    = aux_we;
      end
      default: ;
    endcase
  end

  assign rd_owner_d = ((owner != OWN_NONE) && !mem_we) ? owner : OWN_NONE;

  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign aux_rvalid = (rd_owner_q == OWN_AUX);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign aux_rdata  = aux_rvalid ? mem_rdata : aux_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_owner_q  <= OWN_NONE;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      state_q     <= IDLE;
    end else begin
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      rd_owner_q  <= rd_owner_d;
      cpu_rdata_q <= cpu_rdata;
      aux_rdata_q <= aux_rdata;
      unique case (owner)
        OWN_CPU: state_q <= CPU;
        OWN_AUX: state_q <= AUX;
        default: state_q <= IDLE;
      endcase
    end
  end

  // An idle tracker state always means no read is in flight.
  a_idle_no_read: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == IDLE) |-> (rd_owner_q == OWN_NONE));

endmodule

// File: doc/grom_mem_arbiter.md
# grom_mem_arbiter

- Shares the single-port synchronous `ram_memory` between the `grom_cpu` bus and a secondary auxiliary master (program loader / display DMA).
- Sits between both masters and the RAM in the top level, and absorbs the CPU's `ioreq`/write-enable gating.
- Arbitration is fixed-priority CPU, with a starvation guard that forces an auxiliary slot.
- Read data is steered back to whichever master owned the cycle that issued the read.

## Interface

Parameters:
- `ADDR_W`, 12, address width.
- `DATA_W`, 8, data width.
- `MAX_WAIT`, 15, consecutive denied aux cycles before a forced aux grant (1..255).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request, this cycle.
- `cpu_we`  in  1  CPU write.
- `cpu_ioreq`  in  1  CPU access targets I/O, not RAM.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_wait`  out  1  CPU must hold its request and retry next cycle.
- `cpu_rdata`  out  DATA_W  read data to CPU.
- `cpu_rvalid`  out  1  `cpu_rdata` valid.
- `aux_req`  in  1  aux access request; held until granted.
- `aux_we`  in  1  aux write.
- `aux_addr`  in  ADDR_W  aux address.
- `aux_wdata`  in  DATA_W  aux write data.
- `aux_gnt`  out  1  aux access accepted this cycle.
- `aux_rdata`  out  DATA_W  read data to aux.
- `aux_rvalid`  out  1  `aux_rdata` valid.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_rdata`  in  DATA_W  RAM read data, one cycle after address.

## Operation

- **CPU RAM access:** `cpu_req & ~cpu_ioreq`.
- **CPU I/O access:** `cpu_req & cpu_ioreq`.
  - Never consumes the RAM slot and never stalls.
  - `mem_we` is never driven by an I/O access.
  - The aux master may use the RAM in the same cycle.
- **Owner each cycle** (combinational), first match wins:
  - `force` set: aux is owner if `aux_req`; CPU RAM access gets `cpu_wait`=1.
  - CPU RAM access: CPU is owner; a pending aux gets `aux_gnt`=0.
  - `aux_req`: aux is owner.
  - Otherwise: none; `mem_we`=0 and `mem_addr` holds the last value.
- **RAM drive:** `mem_addr`, `mem_wdata` and `mem_we` are muxed from the owner.
  - `mem_we` = owner's `we`.
- **Starvation counter `wait_cnt`:**
  - Increments on each cycle `aux_req`=1 and aux is not owner.
  - Clears on an aux grant, or on `aux_req`=0.
  - Saturates at MAX_WAIT.
  - `force` = (`wait_cnt` == MAX_WAIT).
- **Read return:** registered `rd_owner` ∈ {NONE, CPU, AUX} records the owner of a read.
  - One cycle later, the matching `*_rvalid`=1 and `*_rdata`=`mem_rdata`.
  - The non-matching `*_rdata` holds its previous value.
- **FSM `arb_state`**, tracks the last owner for debug/observability:
  - IDLE → CPU on a CPU grant; IDLE → AUX on an aux grant.
  - CPU → AUX when forced; AUX → CPU when CPU requests without `force`.
  - Any state → IDLE when no owner.
  - Priority rules above are authoritative; the state never alters a grant.

## Timing

- **Grant latency:** zero cycles; `aux_gnt`/`cpu_wait` are combinational from the requests and `wait_cnt`.
- **Read latency:** 1 cycle, address cycle to `*_rvalid`. Back-to-back reads run one per cycle.
- **Writes:** commit at the clock edge ending the grant cycle; no `rvalid`.
- **Forced cycle:** CPU stalls exactly 1 cycle, then `wait_cnt`=0 and CPU priority resumes.
- **Worst-case aux latency:** MAX_WAIT+1 cycles from `aux_req` rise.
- **Reset values (async assert, sync-safe deassert):**
  - `wait_cnt`=0, `rd_owner`=NONE, `arb_state`=IDLE.
  - `cpu_rvalid`=`aux_rvalid`=0, `cpu_rdata`=`aux_rdata`=0, held `mem_addr`=0.
  - Combinational outputs with all inputs low: `cpu_wait`=0, `aux_gnt`=0, `mem_we`=0.
- **Reset mid-read:** the pending `rvalid` is dropped; no stale valid after deassert.
- **Simultaneous CPU I/O + aux request:** aux granted, `wait_cnt` cleared.
- **`aux_req` deasserted while forced:** no grant, CPU not stalled (force requires `aux_req`).

## Structure

- Shared package `grom_pkg`:
  - `arb_state_t` {IDLE, CPU, AUX}.
  - `owner_t` {OWN_NONE, OWN_CPU, OWN_AUX}.
  - Default ADDR_W/DATA_W constants.
- One sub-module, `grom_starve_cnt`: saturating counter with inc/clr inputs, a `sat` flag and a MAX parameter. Reused by future I/O arbiters.

## Test plan

- **Reset:** assert `reset_n`=0 mid-read → all `rvalid`=0, `wait_cnt`=0; after release with no requests, `mem_we`=0 and `arb_state`=IDLE.
- **CPU priority:** CPU read @0x010 and aux read @0x020 same cycle → `mem_addr`=0x010, `aux_gnt`=0; next cycle `cpu_rvalid`=1 with RAM[0x010].
- **Starvation, MAX_WAIT=3:** continuous CPU RAM reads plus `aux_req` → `aux_gnt`=1 on the 4th cycle, `cpu_wait`=1 that cycle only, CPU granted again the next cycle.
- **I/O bypass:** CPU write with `ioreq`=1 and aux write 0x55@0x100 same cycle → `mem_we` from aux only, RAM[0x100]=0x55, `cpu_wait`=0.
- **Idle aux burst:** aux reads 0x000..0x003 back-to-back with CPU idle → `aux_rvalid` on 4 consecutive cycles, data in order.
- **Steering:** alternating CPU/aux reads → each `rdata` goes only to the issuing master; the other port's `rvalid` stays 0.
